encoder: RTL and testbench
==========================

// Module: encoder
// PURPOSE
//  Keypad encoder for the microwave front panel. Converts a 10-key numeric pad into a
//  4-bit BCD digit plus an active-low load strobe for the time-entry register.
//  Also generates the pgt_1Hz countdown tick, which runs only while cooking is enabled.
//  Sits between the raw keypad and the timer/entry datapath.
// PARAMETERS
//  DIV      10   clk cycles per pgt_1Hz period (>=2); top level overrides with clk_Hz/1Hz
// PORTS
//  clk      in   1   single system clock; all state updates on rising edge
//  rst_n    in   1   synchronous active-low reset, sampled on rising clk
//  numpad   in   10  key lines; numpad[i]=1 means key "i" is pressed (i=0..9)
//  enable   in   1   1 = cooking running (keypad locked, tick runs); 0 = entry mode
//  D        out  4   BCD code of the pressed key (0..9)
//  loadn    out  1   active-low load strobe; low while a valid key is accepted
//  pgt_1Hz  out  1   divided-clock tick, square wave of period DIV cycles
// BEHAVIOUR
//  Reset: synchronous, active-low. While rst_n=0 at a clk edge: divider count<=0,
//   pgt_1Hz<=0. loadn forced 1 and D forced 0 combinationally while rst_n=0.
//  Key encode (combinational, zero latency, so key pulses shorter than a clk period
//   are not missed):
//   - key_any = |numpad. Priority: highest index wins (numpad[9] over [8] ... over [0]).
//   - D = index of highest set bit; D = 4'd0 when no key pressed.
//   - loadn = ~(key_any & ~enable & rst_n). Keys are ignored (loadn=1) while enable=1.
//   - Downstream register loads D on the rising edge of loadn (key release); D must
//     remain stable while loadn is low.
//   - Codes 10..15 never produced. X/Z on numpad: no requirement beyond simulation.
//  1 Hz tick (registered):
//   - 'cnt', width $clog2(DIV), counts 0..DIV-1 and wraps to 0 while enable=1.
//   - pgt_1Hz <= (enable && next_cnt < DIV/2)? Precisely: at edge with enable=1,
//     pgt_1Hz <= (cnt < DIV/2), cnt <= (cnt==DIV-1)?0:cnt+1.
//   - First edge sampling enable=1 with cnt=0 drives pgt_1Hz=1 (1 cycle latency).
//   - High DIV/2 (floor) cycles, low DIV-DIV/2 cycles per period.
//   - enable=0 at an edge: cnt<=0, pgt_1Hz<=0 (tick phase restarts on next enable).
//   - Reset overrides enable; enable toggling mid-period restarts cleanly.
//  Simultaneous key press and enable=1: no strobe, tick unaffected.
// STRUCTURE
//  Shared package: KEY_W=10, BCD_W=4, default DIV constant.
//  One natural sub-module: clk_div (cnt + pgt_1Hz, ports clk,rst_n,en,tick).
//  Priority encoder stays inline as a combinational always block / function.
// TESTING
//  1 Reset: rst_n=0 two edges, enable=1 -> pgt_1Hz=0, loadn=1, D=0 throughout.
//  2 Keys: enable=0, numpad=10'b1 for 2 ns then 0 -> loadn low during pulse, D=0;
//    numpad=10'b0000100000 -> D=5, loadn=0; release -> loadn=1.
//  3 Priority: numpad=10'b1000000101 -> D=9; 10'b0000000101 -> D=2.
//  4 Lock: enable=1, numpad[7]=1 -> loadn stays 1 for whole press.
//  5 Tick: DIV=10, enable rises -> pgt_1Hz high 1 cycle later for 5 cycles, low 5,
//    repeating; 100 cycles -> exactly 10 rising edges.
//  6 Stop: enable=0 mid-high phase -> pgt_1Hz=0 next edge; re-enable restarts at phase 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared widths, default tick divider and the keypad priority encoder.
package encoder_pkg;

    localparam int unsigned KEY_W       = 10;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned DIV_DEFAULT = 10;

    // Ascending scan so the highest pressed key is the last one written.
    function automatic logic [BCD_W-1:0] prio_enc(input logic [KEY_W-1:0] keys);
        prio_enc = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (keys[i]) begin
                prio_enc = BCD_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/encoder_clk_div.sv
// Countdown tick divider: square wave of period DIV, high for the first DIV/2 cycles.
module clk_div #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            tick <= (cnt < HALF);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end else begin
            // Dropping enable restarts the phase so the next run begins high.
            cnt  <= '0;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/encoder.sv
// Keypad encoder: combinational BCD code and load strobe, plus the cooking tick.
module encoder
    import encoder_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] numpad,
    input  logic             enable,
    output logic [BCD_W-1:0] D,
    output logic             loadn,
    output logic             pgt_1Hz
);

    logic key_any;

    // Zero-latency path so key pulses shorter than a clock period still strobe.
    always_comb begin
        key_any = |numpad;
        D       = rst_n ? prio_enc(numpad) : '0;
        loadn   = ~(key_any & ~enable & rst_n);
    end

    clk_div #(
        .DIV(DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (enable),
        .tick (pgt_1Hz)
    );

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the keypad encoder and its cooking tick.
module tb_encoder;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] numpad;
    logic       enable;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;

    int tests = 0;
    int fails = 0;

    encoder #(
        .DIV(DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .numpad (numpad),
        .enable (enable),
        .D      (D),
        .loadn  (loadn),
        .pgt_1Hz(pgt_1Hz)
    );

    always #5 clk = ~clk;

    // Reference key code: floor(log2(keys)), 0 with no key.
    function automatic int ref_code(input logic [9:0] keys);
        int v;
        v = int'(keys);
        ref_code = (v == 0) ? 0 : $clog2(v + 1) - 1;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        numpad = 10'b1000000000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tests++;
            if (pgt_1Hz !== 1'b0 || loadn !== 1'b1 || D !== 4'd0) begin
                fails++;
                $display("FAIL reset: pgt=%b loadn=%b D=%0d, want pgt=0 loadn=1 D=0", pgt_1Hz, loadn, D);
            end
        end
        rst_n  = 1'b1;
        enable = 1'b0;
        numpad = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_keys();
        enable = 1'b0;
        numpad = 10'b0000000001;
        #1;
        tests++;
        if (loadn !== 1'b0 || D !== 4'd0) begin
            fails++;
            $display("FAIL key0_pulse: loadn=%b D=%0d, want loadn=0 D=0", loadn, D);
        end
        #1;
        numpad = '0;
        #1;
        tests++;
        if (loadn !== 1'b1) begin
            fails++;
            $display("FAIL key0_release: loadn=%b, want 1", loadn);
        end
        numpad = 10'b0000100000;
        #1;
        tests++;
        if (loadn !== 1'b0 || D !== 4'd5) begin
            fails++;
            $display("FAIL key5: loadn=%b D=%0d, want loadn=0 D=5", loadn, D);
        end
        @(posedge clk); #1;
        tests++;
        if (loadn !== 1'b0 || D !== 4'd5) begin
            fails++;
            $display("FAIL key5_held: loadn=%b D=%0d, want loadn=0 D=5", loadn, D);
        end
        numpad = '0;
        #1;
        tests++;
        if (loadn !== 1'b1) begin
            fails++;
            $display("FAIL key5_release: loadn=%b, want 1", loadn);
        end
    endtask

    task automatic test_priority();
        logic [9:0] pats [4];
        int         want [4];
        pats[0] = 10'b1000000101; want[0] = 9;
        pats[1] = 10'b0000000101; want[1] = 2;
        pats[2] = 10'b0100000000; want[2] = 8;
        pats[3] = 10'b1111111111; want[3] = 9;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            numpad = pats[i];
            #1;
            tests++;
            if (D !== want[i][3:0] || loadn !== 1'b0) begin
                fails++;
                $display("FAIL priority[%0d]: D=%0d loadn=%b, want D=%0d loadn=0", i, D, loadn, want[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            logic [9:0] k;
            logic       e;
            k = 10'($urandom);
            if ($urandom_range(0, 7) == 0) k = '0;
            e = 1'($urandom);
            numpad = k;
            enable = e;
            #1;
            tests++;
            if (D !== 4'(ref_code(k)) || loadn !== ~((k != 0) && !e)) begin
                fails++;
                $display("FAIL rand_key: keys=%b en=%b D=%0d loadn=%b, want D=%0d loadn=%b",
                         k, e, D, loadn, ref_code(k), ~((k != 0) && !e));
            end
        end
        numpad = '0;
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lock();
        enable = 1'b1;
        numpad = 10'b0010000000;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (loadn !== 1'b1) begin
                fails++;
                $display("FAIL lock: loadn=%b, want 1", loadn);
            end
            @(posedge clk);
        end
        numpad = '0;
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tick();
        int prev;
        int rises;
        int n;
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        prev   = 0;
        rises  = 0;
        n      = 0;
        for (int i = 0; i < 100; i++) begin
            logic want;
            want = ((n % DIV) < DIV / 2);
            n++;
            @(posedge clk); #1;
            tests++;
            if (pgt_1Hz !== want) begin
                fails++;
                $display("FAIL tick cycle %0d: pgt=%b, want %b", i, pgt_1Hz, want);
            end
            if (prev == 0 && pgt_1Hz === 1'b1) rises++;
            prev = (pgt_1Hz === 1'b1) ? 1 : 0;
        end
        tests++;
        if (rises != 10) begin
            fails++;
            $display("FAIL tick_rises: got %0d, want 10", rises);
        end
    endtask

    task automatic test_stop();
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (pgt_1Hz !== 1'b0) begin
            fails++;
            $display("FAIL stop: pgt=%b, want 0", pgt_1Hz);
        end
        enable = 1'b1;
        for (int i = 0; i < DIV; i++) begin
            @(posedge clk); #1;
            tests++;
            if (pgt_1Hz !== (i < DIV / 2)) begin
                fails++;
                $display("FAIL restart cycle %0d: pgt=%b, want %b", i, pgt_1Hz, (i < DIV / 2));
            end
        end
    endtask

    task automatic test_random_tick();
        int  n;
        logic want;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            rst_n  = ($urandom_range(0, 39) != 0);
            enable = ($urandom_range(0, 15) != 0);
            numpad = 10'($urandom);
            if (!rst_n || !enable) begin
                want = 1'b0;
                n    = 0;
            end else begin
                want = ((n % DIV) < DIV / 2);
                n++;
            end
            @(posedge clk); #1;
            tests++;
            if (pgt_1Hz !== want) begin
                fails++;
                $display("FAIL rand_tick cycle %0d: pgt=%b, want %b", i, pgt_1Hz, want);
            end
            tests++;
            if (loadn !== ~((numpad != 0) && !enable && rst_n) ||
                D !== (rst_n ? 4'(ref_code(numpad)) : 4'd0)) begin
                fails++;
                $display("FAIL rand_keys cycle %0d: D=%0d loadn=%b", i, D, loadn);
            end
        end
        rst_n  = 1'b1;
        enable = 1'b0;
        numpad = '0;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        numpad = '0;
        test_reset();
        test_keys();
        test_priority();
        test_lock();
        test_tick();
        test_stop();
        test_random_tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
